// File: rtl/rand_server_arbiter.sv
// Round-robin server that hands out a wrapping free-running counter value to
// NUM_REQ requesters over a 4-phase req/ack handshake. Optional per-frame quota via RAND_FRAME_QUOTA_EN.
module rand_server_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_BITS = 8,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 255
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         ack,
    output logic [SIZE_BITS-1:0]       dout,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [SIZE_BITS-1:0] MIN_V    = SIZE_BITS'(MIN_VAL);
    localparam logic [SIZE_BITS-1:0] MAX_V    = SIZE_BITS'(MAX_VAL);
    localparam logic [SIZE_BITS-1:0] MID_V    = SIZE_BITS'((MAX_VAL + MIN_VAL) / 2);
    localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]           state;
    logic [SIZE_BITS-1:0] counter;
    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   eligible;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     next_ptr;

    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            counter <= MIN_V;
        else if (counter >= MAX_V)
            counter <= MIN_V;
        else
            counter <= counter + 1'b1;
    end

`ifdef RAND_FRAME_QUOTA_EN
    logic [NUM_REQ-1:0] quota;

    // A frame start clears every flag, overriding a flag set by a coincident grant.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            quota <= '0;
        else if (startOfFrame)
            quota <= '0;
        else if (state == GRANT && req[grant_id])
            quota[grant_id] <= 1'b1;
    end

    assign eligible = req & ~quota;
`else
    logic unused_sof;
    assign unused_sof = startOfFrame;
    assign eligible   = req;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            ack      <= '0;
            dout     <= MID_V;
            grant_id <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_id <= win_idx;
                        state    <= GRANT;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (req[grant_id]) begin
                        dout   <= counter;
                        ack    <= NUM_REQ'(1) << grant_id;
                        rr_ptr <= next_ptr;
                        state  <= HOLD;
                    end else begin
                        // Requester withdrew before service: no ack, pointer stays put.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!req[grant_id]) begin
                        ack   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_server_arbiter.sv
// Directed self-checking bench for rand_server_arbiter (MIN_VAL=10, MAX_VAL=20).
// Covers RAND_FRAME_QUOTA_EN when the macro is defined for the build.
module tb_rand_server_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int SIZE_BITS = 8;
    localparam int MIN_VAL   = 10;
    localparam int MAX_VAL   = 20;
    localparam int RANGE     = MAX_VAL - MIN_VAL + 1;
    localparam logic [SIZE_BITS-1:0] MID = 8'd15;

    logic                 clk;
    logic                 resetN;
    logic                 startOfFrame;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   ack;
    logic [SIZE_BITS-1:0] dout;
    logic [1:0]           grant_id;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    int cyc;

    rand_server_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .SIZE_BITS(SIZE_BITS),
        .MIN_VAL  (MIN_VAL),
        .MAX_VAL  (MAX_VAL)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .req         (req),
        .ack         (ack),
        .dout        (dout),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset release; the counter value follows directly from it.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic [SIZE_BITS-1:0] exp_cnt();
        return SIZE_BITS'(MIN_VAL + (cyc % RANGE));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        req = '0;
        startOfFrame = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((busy !== 1'b0 || ack !== '0) && c < 10) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b ack=%b, required idle", busy, ack);
        end
    endtask

    task automatic run_txn(input int idx, input int max_cyc, output bit got);
        got = 1'b0;
        req[idx] = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (ack[idx] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        req[idx] = 1'b0;
        @(negedge clk);
        wait_idle();
    endtask

    task automatic test_reset();
        logic [SIZE_BITS-1:0] prev;
        bit saw_wrap;
        resetN = 1'b0;
        req = '0;
        startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== '0 || dout !== MID || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dout=%0d busy=%b gid=%0d, required 0/15/0/0",
                     ack, dout, busy, grant_id);
        end
        resetN = 1'b1;
        prev = dut.counter;
        saw_wrap = 1'b0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            checks++;
            if (dut.counter !== exp_cnt() || dut.counter < 8'(MIN_VAL) || dut.counter > 8'(MAX_VAL)) begin
                errors++;
                $display("FAIL counter_seq: got %0d required %0d", dut.counter, exp_cnt());
            end
            if (prev == 8'(MAX_VAL) && dut.counter == 8'(MIN_VAL)) saw_wrap = 1'b1;
            prev = dut.counter;
        end
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL counter_wrap: wrap 20->10 seen=%b required 1", saw_wrap);
        end
    endtask

    task automatic test_single_grant();
        logic [SIZE_BITS-1:0] exp_d;
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ack !== '0 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL single_grant_state: busy=%b ack=%b gid=%0d required 1/0000/1", busy, ack, grant_id);
        end
        exp_d = exp_cnt();
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010 || dout !== exp_d) begin
            errors++;
            $display("FAIL single_ack: ack=%b dout=%0d required 0010/%0d", ack, dout, exp_d);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 4'b0010 || dout !== exp_d || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: ack=%b dout=%0d busy=%b required 0010/%0d/1", ack, dout, busy, exp_d);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (ack !== '0 || busy !== 1'b0 || dout !== exp_d || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL single_release: ack=%b busy=%b dout=%0d gid=%0d required 0000/0/%0d/1",
                     ack, busy, dout, grant_id, exp_d);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int k;
        int seen;
        do_reset();
        k = 0;
        req = 4'hF;
        for (int c = 0; c < 80 && k < 5; c++) begin
            @(negedge clk);
            checks++;
            if ($countones(ack) > 1) begin
                errors++;
                $display("FAIL rr_onehot: ack=%b has more than one bit set", ack);
            end
            if (ack != '0) begin
                seen = 0;
                for (int b = 0; b < NUM_REQ; b++) if (ack[b]) seen = b;
                checks++;
                if (seen != order[k]) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d went to %0d required %0d", k, seen, order[k]);
                end
                k++;
                req[seen] = 1'b0;
            end else begin
                req = 4'hF;
            end
        end
        checks++;
        if (k != 5) begin
            errors++;
            $display("FAIL rr_timeout: %0d grants seen, required 5", k);
        end
        req = '0;
        @(negedge clk);
        wait_idle();
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL withdraw_grant: busy=%b gid=%0d required 1/2", busy, grant_id);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL withdraw_idle: busy=%b ack=%b required 0/0000", busy, ack);
        end
        req = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL withdraw_next: ack=%b gid=%0d required 0010/1", ack, grant_id);
        end
        req = '0;
        @(negedge clk);
        wait_idle();
    endtask

    task automatic test_reset_in_hold();
        // Pointer sits at 2 after the previous grant to requester 1.
        req = 4'b0100;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 4'b0100) begin
            errors++;
            $display("FAIL hold_setup: ack=%b required 0100", ack);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (ack !== '0 || dout !== MID || busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: ack=%b dout=%0d busy=%b gid=%0d required 0000/15/0/0",
                     ack, dout, busy, grant_id);
        end
        @(negedge clk);
        req = '0;
        resetN = 1'b1;
    endtask

    task automatic test_frame_quota();
        bit got;
        bit any_ack;
        do_reset();
        run_txn(0, 6, got);
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL quota_first: req0 served=%b required 1", got);
        end
`ifdef RAND_FRAME_QUOTA_EN
        req[0] = 1'b1;
        any_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0] === 1'b1 || busy === 1'b1) any_ack = 1'b1;
        end
        checks++;
        if (any_ack !== 1'b0) begin
            errors++;
            $display("FAIL quota_block: req0 activity=%b required 0", any_ack);
        end
        run_txn(1, 6, got);
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL quota_other: req1 served=%b required 1", got);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ack[0] !== 1'b0) begin
            errors++;
            $display("FAIL quota_still_blocked: ack0=%b required 0", ack[0]);
        end
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL quota_after_frame: req0 served=%b required 1", got);
        end
        req[0] = 1'b0;
        @(negedge clk);
        wait_idle();
`else
        any_ack = 1'b0;
        run_txn(0, 6, got);
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL noquota_repeat: req0 served=%b required 1", got);
        end
        startOfFrame = 1'b1;
        run_txn(1, 6, got);
        startOfFrame = 1'b0;
        checks++;
        if (got !== 1'b1 || any_ack !== 1'b0) begin
            errors++;
            $display("FAIL noquota_sof: req1 served=%b required 1", got);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_withdraw();
        test_reset_in_hold();
        test_frame_quota();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rand_server_arbiter.md
Name: rand_server_arbiter

Overview:
- Shares one range-limited random-value source among NUM_REQ requesters, e.g. enemy direction pickers and bonus-drop logic.
- Uses a round-robin arbiter and a 4-phase req/ack handshake.
- The random value is a free-running wrapping counter sampled at the moment a grant is issued. Requester timing therefore decorrelates the values.
- Sits between the game-logic requesters and the frame timing (startOfFrame).

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- SIZE_BITS, 8: width of the random value.
- MIN_VAL, 0: lowest value produced (unsigned).
- MAX_VAL, 255: highest value produced (unsigned). MIN_VAL <= MAX_VAL < 2**SIZE_BITS.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at each video frame start.
- req  in  NUM_REQ  per-requester level request; held until ack is seen, then dropped.
- ack  out  NUM_REQ  per-requester acknowledge, one-hot or zero; dout is valid while ack[i]=1.
- dout  out  SIZE_BITS  random value delivered to the granted requester.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, resetN=0):
  - ack=0, dout=(MAX_VAL+MIN_VAL)/2, grant_id=0, busy=0.
  - counter=MIN_VAL, rr pointer=0, state=IDLE, quota flags cleared.
- Reset mid-handshake aborts immediately to these values. All outputs are registered.
- Counter:
  - Increments every clk. If counter >= MAX_VAL, the next value is MIN_VAL.
  - Never leaves [MIN_VAL, MAX_VAL].
  - MIN_VAL==MAX_VAL gives a constant counter.
- Round-robin: search starts at the rr pointer and wraps modulo NUM_REQ. The first eligible req[i]=1 wins.
- State IDLE (busy=0):
  - If any eligible req: latch winner into grant_id and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT (one cycle, busy=1):
  - If req[grant_id]=1: dout<=counter, ack[grant_id]<=1, rr pointer<=(grant_id+1) mod NUM_REQ, go to HOLD.
  - If req[grant_id]=0 (requester withdrew): no ack, pointer unchanged, go to IDLE.
- State HOLD (busy=1):
  - ack[grant_id] and dout are held stable.
  - When req[grant_id]=0 is sampled: ack<=0, go to IDLE.
  - Other requesters' req changes are ignored until IDLE.
- Latency:
  - req sampled high in IDLE at edge N gives GRANT after edge N, and ack=1 after edge N+1 (2 clocks).
  - After req drops, ack falls one edge later.
  - Minimum full transaction is 4 cycles. A new grant can be issued from IDLE on the cycle after ack falls.
- Simultaneous requests: only one grant at a time. Under sustained all-high requests, grants rotate strictly 0,1,2,3,0...
- dout keeps its last delivered value between grants. grant_id keeps the last winner.
- startOfFrame has no effect unless the optional feature is compiled in.

Optional Feature:
- Macro: RAND_FRAME_QUOTA_EN.
- Defined:
  - Per-requester quota flag set when ack[i] rises.
  - A requester with its flag set is ineligible in IDLE.
  - startOfFrame=1 clears all flags on that edge. If startOfFrame coincides with a grant to i, flag i is cleared; the clear wins.
  - This limits each requester to at most one value per frame. Its req simply waits; ack is never given.
- Undefined: no quota logic; every requester is always eligible.

Test Plan:
- Reset with MIN_VAL=10, MAX_VAL=20 -> dout=15, ack=0, busy=0; the internal counter cycles 10..20 and wraps to 10, never 21.
- req=4'b0010 held from IDLE -> ack=4'b0010 exactly 2 clocks later; dout equals the counter value at the GRANT cycle; ack clears 1 clock after req drops; busy falls with it.
- req=4'b1111 held, with each requester dropping req one clock after its ack and re-raising it -> grant order 0,1,2,3,0; never two ack bits high together.
- req[2] raised, then dropped during GRANT -> no ack pulse, state back to IDLE, next grant with req=4'b0110 goes to requester 1 (pointer unchanged).
- resetN pulsed low while in HOLD with ack=4'b0100 -> ack=0, dout=midpoint, busy=0 immediately, asynchronously.
- RAND_FRAME_QUOTA_EN: requester 0 served once, then re-requests -> no ack until after the next startOfFrame pulse; requester 1 is still served in the meantime.
